// File: rtl/lcd_pkg.sv
// lcd_pkg: shared opcode, state and width definitions for the LCD command path
package lcd_pkg;
  localparam int LCD_OPW = 4;
  localparam logic [LCD_OPW-1:0] OP_WRITE       = 4'd0;
  localparam logic [LCD_OPW-1:0] OP_SHIFT_UP    = 4'd1;
  localparam logic [LCD_OPW-1:0] OP_SHIFT_DOWN  = 4'd2;
  localparam logic [LCD_OPW-1:0] OP_SHIFT_LEFT  = 4'd3;
  localparam logic [LCD_OPW-1:0] OP_SHIFT_RIGHT = 4'd4;
  localparam logic [LCD_OPW-1:0] OP_MAX         = 4'd5;
  localparam logic [LCD_OPW-1:0] OP_MIN         = 4'd6;
  localparam logic [LCD_OPW-1:0] OP_AVERAGE     = 4'd7;
  localparam logic [LCD_OPW-1:0] OP_COUNTER_CW  = 4'd8;
  localparam logic [LCD_OPW-1:0] OP_CLOCKWISE   = 4'd9;
  localparam logic [LCD_OPW-1:0] OP_MIRROR_X    = 4'd10;
  localparam logic [LCD_OPW-1:0] OP_MIRROR_Y    = 4'd11;
  localparam logic [LCD_OPW-1:0] OP_ILLEGAL_MIN = 4'd12;
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t S_IDLE      = 3'd0;
  localparam seq_state_t S_FETCH     = 3'd1;
  localparam seq_state_t S_LOAD      = 3'd2;
  localparam seq_state_t S_ISSUE     = 3'd3;
  localparam seq_state_t S_ACK       = 3'd4;
  localparam seq_state_t S_WAIT_DONE = 3'd5;
  localparam seq_state_t S_FINISH    = 3'd6;
  function automatic logic is_illegal(input logic [LCD_OPW-1:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction
endpackage

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: fetches opcodes from a command ROM and issues them to the LCD controller
// Ports: clk, reset (async, active-high), start (pulse, honoured only in IDLE),
//   crom_rd/crom_a/crom_q (ROM read, data one cycle after crom_rd),
//   cmd/cmd_valid (issue strobe while busy low), busy/done (controller handshake),
//   seq_done (high in FINISH), issued_cnt (saturating issue count).
// Build option: LCD_SEQ_SKIP_ILLEGAL_EN drops opcodes 12..15 instead of issuing them.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int AW  = 6,
  parameter int OPW = LCD_OPW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          crom_rd,
  output logic [AW-1:0] crom_a,
  input  logic [OPW-1:0] crom_q,
  output logic [OPW-1:0] cmd,
  output logic          cmd_valid,
  input  logic          busy,
  input  logic          done,
  output logic          seq_done,
  output logic [AW:0]   issued_cnt
);
  seq_state_t state;
  logic [AW-1:0] ptr;
  logic [OPW-1:0] op, last_cmd;
  logic last, skip;
  assign last = ptr == '1;
`ifdef LCD_SEQ_SKIP_ILLEGAL_EN
  assign skip = is_illegal(crom_q);
`else
  assign skip = 1'b0;
`endif
  assign crom_rd   = state == S_FETCH;
  assign crom_a    = ptr;
  assign cmd       = state == S_ISSUE ? op : last_cmd;
  assign cmd_valid = state == S_ISSUE && !busy;
  assign seq_done  = state == S_FINISH;
  // Past the last ROM entry the pointer never wraps; a WRITE is forced instead.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      op         <= '0;
      last_cmd   <= '0;
      issued_cnt <= '0;
    end else
      case (state)
        S_IDLE:
          if (start) begin
            ptr        <= '0;
            issued_cnt <= '0;
            state      <= S_FETCH;
          end
        S_FETCH: state <= S_LOAD;
        S_LOAD:
          if (skip) begin
            if (last) begin
              op    <= '0;
              state <= S_ISSUE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= S_FETCH;
            end
          end else begin
            op    <= crom_q;
            state <= S_ISSUE;
          end
        S_ISSUE:
          if (!busy) begin
            last_cmd   <= op;
            issued_cnt <= issued_cnt == '1 ? issued_cnt : issued_cnt + 1'b1;
            state      <= S_ACK;
          end
        S_ACK:
          if (busy || done) begin
            if (op == '0) state <= S_WAIT_DONE;
            else if (last) begin
              op    <= '0;
              state <= S_ISSUE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= S_FETCH;
            end
          end
        S_WAIT_DONE: if (done) state <= S_FINISH;
        default: state <= state;
      endcase
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: scoreboard bench with a ROM and controller model for lcd_cmd_sequencer
module tb_lcd_cmd_sequencer;
  localparam int AW = 6, OPW = 4;
  logic clk = 0, reset = 1, start = 0;
  logic crom_rd, cmd_valid, seq_done, busy;
  logic done = 0;
  logic [AW-1:0] crom_a;
  logic [OPW-1:0] crom_q = '0, cmd;
  logic [AW:0] issued_cnt;
  logic ctrl_busy = 0, force_busy = 0;
  logic [OPW-1:0] rom [64];
  logic [OPW-1:0] exp_q [$];
  int checks = 0, failures = 0, exp_addr = 0, exp_issued = 0, bcnt = 0;
  logic issued_flag = 0, done_pend = 0, done_prev = 0, found;
  logic [OPW-1:0] issued_cmd = '0;
  assign busy = ctrl_busy | force_busy;
  lcd_cmd_sequencer #(.AW(AW), .OPW(OPW)) dut (
    .clk(clk), .reset(reset), .start(start), .crom_rd(crom_rd), .crom_a(crom_a),
    .crom_q(crom_q), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .seq_done(seq_done), .issued_cnt(issued_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (crom_rd) crom_q <= rom[crom_a];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd actual=%0d required=none", cmd);
      end else check("cmd", cmd, exp_q.pop_front());
      check("issued_cnt_at_issue", issued_cnt, exp_issued);
      exp_issued++;
      issued_flag = 1;
      issued_cmd = cmd;
    end
    if (crom_rd === 1'b1) begin
      check("crom_a", crom_a, exp_addr);
      exp_addr++;
    end
    if (done_prev) check("seq_done_after_done", seq_done, 1);
    done_prev = done;
  end
  always @(posedge clk) begin
    #1;
    if (reset) begin
      issued_flag = 0;
      bcnt = 0;
      done_pend = 0;
      ctrl_busy = 0;
      done = 0;
    end else begin
      if (issued_flag) begin
        issued_flag = 0;
        bcnt = 2;
        done_pend = issued_cmd == 0;
      end
      done = done_pend && bcnt == 0;
      if (done) done_pend = 0;
      ctrl_busy = bcnt > 0;
      if (bcnt > 0) bcnt--;
    end
  end
  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic begin_seq();
    exp_addr = 0;
    exp_issued = 0;
    pulse_start();
  endtask
  task automatic do_reset();
    @(negedge clk) reset = 1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk) reset = 0;
    done_prev = 0;
  endtask
  task automatic wait_finish(input int budget, input string name);
    int n = 0;
    while (seq_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, seq_done, 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_crom_rd"}, crom_rd, 0);
    check({tag, "_crom_a"}, crom_a, 0);
    check({tag, "_cmd"}, cmd, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_seq_done"}, seq_done, 0);
    check({tag, "_issued_cnt"}, issued_cnt, 0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 0;
    rom[0] = 1; rom[1] = 4; rom[2] = 5; rom[3] = 0;
    exp_q = {4'd1, 4'd4, 4'd5, 4'd0};
    begin_seq();
    wait_finish(300, "t1_seq_done");
    check("t1_issued_cnt", issued_cnt, 4);
    check("t1_queue_empty", exp_q.size(), 0);
    pulse_start();
    repeat (5) @(negedge clk);
    check("t1_finish_hold", seq_done, 1);
    check("t1_finish_cnt", issued_cnt, 4);
    do_reset();
    rom[0] = 3; rom[1] = 0;
    force_busy = 1;
    exp_q = {4'd3, 4'd0};
    begin_seq();
    repeat (3) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_busy_no_valid", cmd_valid, 0);
      check("t2_busy_cmd_held", cmd, 3);
    end
    check("t2_busy_cnt", issued_cnt, 0);
    @(posedge clk);
    #1 force_busy = 0;
    wait_finish(300, "t2_seq_done");
    check("t2_issued_cnt", issued_cnt, 2);
    check("t2_queue_empty", exp_q.size(), 0);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      rom[i] = OPW'((i % 11) + 1);
      exp_q.push_back(OPW'((i % 11) + 1));
    end
    exp_q.push_back('0);
    begin_seq();
    wait_finish(2000, "t3_seq_done");
    check("t3_issued_cnt", issued_cnt, 65);
    check("t3_fetches", exp_addr, 64);
    check("t3_queue_empty", exp_q.size(), 0);
    do_reset();
    rom[0] = 13; rom[1] = 2; rom[2] = 0;
`ifdef LCD_SEQ_SKIP_ILLEGAL_EN
    exp_q = {4'd2, 4'd0};
`else
    exp_q = {4'd13, 4'd2, 4'd0};
`endif
    begin_seq();
    wait_finish(300, "t4_seq_done");
`ifdef LCD_SEQ_SKIP_ILLEGAL_EN
    check("t4_issued_cnt", issued_cnt, 2);
`else
    check("t4_issued_cnt", issued_cnt, 3);
`endif
    check("t4_queue_empty", exp_q.size(), 0);
    do_reset();
    rom[0] = 7; rom[1] = 0;
    exp_q = {4'd7, 4'd0};
    begin_seq();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = cmd_valid === 1'b1 && cmd == 7;
    end
    check("t5_cmd7_issued", found, 1);
    @(posedge clk);
    #2 reset = 1;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("t5_midrst");
    reset = 0;
    done_prev = 0;
    rom[0] = 2; rom[1] = 0;
    exp_q = {4'd2, 4'd0};
    begin_seq();
    wait_finish(300, "t5_seq_done");
    check("t5_issued_cnt", issued_cnt, 2);
    check("t5_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
